// File: rtl/sg_fetch.sv
// sg_fetch: single-channel scatter-gather descriptor fetch engine with a Wishbone read master.
// Defining SG_TIMEOUT_EN adds a per-beat response timeout (parameter TIMEOUT).
module sg_fetch #(
  parameter int MAX_RTY = 4
`ifdef SG_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [28:0] start_adr_i,
  input  logic        abort_i,
  output logic        desc_valid_o,
  input  logic        desc_done_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [7:0]  sg_state,
  output logic [15:0] sg_desc,
  output logic [28:0] sg_addr,
  output logic [28:0] sg_next
);

  localparam int RW = $clog2(MAX_RTY + 1);
`ifdef SG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD0   = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_VALID = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  state_t         state_r, state_s;
  logic           cyc_r, cyc_s;
  logic [31:0]    adr_r, adr_s;
  logic [31:0]    beat_ofs_s;
  logic [28:0]    cur_ptr_r, cur_ptr_s;
  logic [RW-1:0]  rty_cnt_r, rty_cnt_s;
  logic [15:0]    desc_tmp_r, desc_tmp_s;
  logic [28:0]    addr_tmp_r, addr_tmp_s;
  logic [15:0]    desc_r, desc_s;
  logic [28:0]    addr_r, addr_s;
  logic [28:0]    next_r, next_s;
  logic           eoc_r, eoc_s;
  logic [3:0]     cnt_r, cnt_s;
  logic           valid_r, valid_s;
`ifdef SG_TIMEOUT_EN
  logic [TW-1:0]  to_cnt_r, to_cnt_s;
`endif
  logic [1:0]     unused_dat_s;

  assign unused_dat_s = wbm_dat_i[2:1];

  // Byte offset of the beat belonging to the current read state.
  always_comb begin
    case (state_r)
      ST_RD1:  beat_ofs_s = 32'd4;
      ST_RD2:  beat_ofs_s = 32'd8;
      default: beat_ofs_s = 32'd0;
    endcase
  end

  // Next-state and next-output logic; abort overrides every other event.
  always_comb begin
    state_s    = state_r;
    cyc_s      = cyc_r;
    adr_s      = adr_r;
    cur_ptr_s  = cur_ptr_r;
    rty_cnt_s  = rty_cnt_r;
    desc_tmp_s = desc_tmp_r;
    addr_tmp_s = addr_tmp_r;
    desc_s     = desc_r;
    addr_s     = addr_r;
    next_s     = next_r;
    eoc_s      = eoc_r;
    cnt_s      = cnt_r;
    valid_s    = valid_r;
`ifdef SG_TIMEOUT_EN
    to_cnt_s   = {TW{1'b0}};
`endif
    if (abort_i && (state_r != ST_IDLE)) begin
      state_s   = ST_IDLE;
      cyc_s     = 1'b0;
      valid_s   = 1'b0;
      rty_cnt_s = {RW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            cur_ptr_s = start_adr_i;
            cnt_s     = 4'd0;
            rty_cnt_s = {RW{1'b0}};
            state_s   = ST_RD0;
            cyc_s     = 1'b1;
            adr_s     = {start_adr_i, 3'b000};
          end else begin
            state_s = state_r;
          end
        end
        ST_RD0, ST_RD1, ST_RD2: begin
          // cyc low inside a read state is the one-cycle gap before (re)issuing the beat
          if (!cyc_r) begin
            cyc_s = 1'b1;
            adr_s = {cur_ptr_r, 3'b000} + beat_ofs_s;
          end else if (wbm_err_i) begin
            cyc_s   = 1'b0;
            state_s = ST_ERROR;
          end else if (wbm_ack_i) begin
            cyc_s     = 1'b0;
            rty_cnt_s = {RW{1'b0}};
            case (state_r)
              ST_RD0: begin
                desc_tmp_s = wbm_dat_i[15:0];
                state_s    = ST_RD1;
              end
              ST_RD1: begin
                addr_tmp_s = wbm_dat_i[31:3];
                state_s    = ST_RD2;
              end
              default: begin
                desc_s  = desc_tmp_r;
                addr_s  = addr_tmp_r;
                next_s  = wbm_dat_i[31:3];
                eoc_s   = wbm_dat_i[0];
                cnt_s   = cnt_r + 4'd1;
                valid_s = 1'b1;
                state_s = ST_VALID;
              end
            endcase
          end else if (wbm_rty_i) begin
            cyc_s = 1'b0;
            if (rty_cnt_r == RW'(MAX_RTY)) begin
              state_s = ST_ERROR;
            end else begin
              rty_cnt_s = rty_cnt_r + RW'(1);
            end
          end else begin
`ifdef SG_TIMEOUT_EN
            if (to_cnt_r == TW'(TIMEOUT - 1)) begin
              cyc_s   = 1'b0;
              state_s = ST_ERROR;
            end else begin
              to_cnt_s = to_cnt_r + TW'(1);
            end
`else
            cyc_s = cyc_r;
`endif
          end
        end
        ST_VALID: begin
          if (desc_done_i) begin
            valid_s = 1'b0;
            if (eoc_r) begin
              state_s = ST_DONE;
            end else begin
              cur_ptr_s = next_r;
              state_s   = ST_RD0;
              cyc_s     = 1'b1;
              adr_s     = {next_r, 3'b000};
            end
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cyc_s   = 1'b0;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus, pointer, counter and held-descriptor registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cyc_r      <= 1'b0;
      adr_r      <= 32'd0;
      cur_ptr_r  <= 29'd0;
      rty_cnt_r  <= {RW{1'b0}};
      desc_tmp_r <= 16'd0;
      addr_tmp_r <= 29'd0;
      desc_r     <= 16'd0;
      addr_r     <= 29'd0;
      next_r     <= 29'd0;
      eoc_r      <= 1'b0;
      cnt_r      <= 4'd0;
      valid_r    <= 1'b0;
`ifdef SG_TIMEOUT_EN
      to_cnt_r   <= {TW{1'b0}};
`endif
    end else begin
      cyc_r      <= cyc_s;
      adr_r      <= adr_s;
      cur_ptr_r  <= cur_ptr_s;
      rty_cnt_r  <= rty_cnt_s;
      desc_tmp_r <= desc_tmp_s;
      addr_tmp_r <= addr_tmp_s;
      desc_r     <= desc_s;
      addr_r     <= addr_s;
      next_r     <= next_s;
      eoc_r      <= eoc_s;
      cnt_r      <= cnt_s;
      valid_r    <= valid_s;
`ifdef SG_TIMEOUT_EN
      to_cnt_r   <= to_cnt_s;
`endif
    end
  end

  assign wbm_cyc_o    = cyc_r;
  assign wbm_stb_o    = cyc_r;
  assign wbm_we_o     = 1'b0;
  assign wbm_sel_o    = 4'hf;
  assign wbm_adr_o    = adr_r;
  assign desc_valid_o = valid_r;
  // The EOC flag is reported only while a descriptor is actually held.
  assign sg_state     = {cnt_r, eoc_r & valid_r, state_r};
  assign sg_desc      = desc_r;
  assign sg_addr      = addr_r;
  assign sg_next      = next_r;

endmodule

// File: doc/sg_fetch.md
Name: sg_fetch

Overview:
- Single-channel scatter-gather descriptor fetch engine; one instance per DMA channel (four in total).
- A Wishbone master reads each 16-byte descriptor from system memory and holds it for the data mover.
- The data mover signals when it has consumed the descriptor; the engine then follows the next pointer.
- Drives the sg_stateN/sg_descN/sg_addrN/sg_nextN status buses that the register slave exposes to software.

Parameters:
MAX_RTY, 4, consecutive wbm_rty_i responses tolerated on one beat before the engine flags an error
TIMEOUT, 255, cycles without ack/err/rty before a beat times out (only with SG_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle pulse: begin a chain at start_adr_i
start_adr_i  in  29  [31:3] address of the first descriptor
abort_i  in  1  one-cycle pulse: stop the chain immediately
desc_valid_o  out  1  descriptor held and ready for the data mover
desc_done_i  in  1  one-cycle pulse: data mover has finished the current descriptor
wbm_cyc_o  out  1  Wishbone master cycle
wbm_stb_o  out  1  Wishbone master strobe
wbm_we_o  out  1  always 0
wbm_sel_o  out  4  always 4'b1111
wbm_adr_o  out  32  byte address of the current beat
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  beat acknowledged
wbm_err_i  in  1  bus error
wbm_rty_i  in  1  retry request
sg_state  out  8  status byte (layout below)
sg_desc  out  16  descriptor control word
sg_addr  out  29  [31:3] buffer address
sg_next  out  29  [31:3] next-descriptor address

Behaviour:
- Descriptor in memory, 8-byte aligned, 16 bytes:
  - word0[15:0] = desc; word0[31:16] ignored.
  - word1[31:3] = buffer address; bits [2:0] ignored.
  - word2[31:3] = next pointer; word2[0] = EOC (end of chain).
  - word3 is never fetched.
- FSM state codes: IDLE=0, RD0=1, RD1=2, RD2=3, VALID=4, DONE=5, ERROR=6.
- sg_state layout:
  - [2:0] = FSM state code.
  - [3] = EOC of the held descriptor.
  - [7:4] = count of descriptors fetched since start, modulo 16 (wraps 15->0).
- Reset: all outputs 0 except wbm_sel_o=4'hf; FSM in IDLE; descriptor count 0; retry counter 0.
- IDLE, DONE and ERROR all accept start_i:
  - The cycle after start_i: cur_ptr <= start_adr_i, count cleared, FSM to RD0.
  - wbm_cyc_o=wbm_stb_o=1 and wbm_adr_o={cur_ptr,3'b000}.
- RDn issues a single read beat at {cur_ptr,3'b000}+4n. cyc/stb stay high until ack, err or rty is seen.
- RDn outcome on the response cycle:
  - ack: capture the data field; next cycle deassert cyc/stb for exactly one cycle, then move to RD(n+1). There are no back-to-back beats.
  - rty: deassert for one cycle, increment the retry counter, re-issue the same beat. The counter resets on every ack.
  - rty with the retry count already equal to MAX_RTY: go to ERROR.
  - err: go to ERROR.
  - ack and err in the same cycle: err wins.
- Status latching:
  - sg_desc, sg_addr, sg_next and sg_state[3] update together on the RD2 ack.
  - sg_state[7:4] increments on the RD2 ack.
  - The FSM then enters VALID with desc_valid_o=1. Latency from start_i to desc_valid_o with zero-wait acks is 6 cycles.
- VALID on desc_done_i:
  - desc_valid_o drops the next cycle.
  - If the held descriptor has EOC=1, go to DONE.
  - Otherwise cur_ptr <= sg_next and go to RD0.
- desc_done_i outside VALID is ignored. start_i while busy (RD0-VALID) is ignored.
- abort_i from any non-IDLE state:
  - Next cycle: cyc/stb=0, desc_valid_o=0, FSM to IDLE.
  - A beat that was pending is abandoned.
  - abort_i takes precedence over a same-cycle ack or desc_done_i.
  - sg_desc/addr/next keep their last values.
- ERROR holds cyc/stb=0 until start_i or abort_i. sg_desc/addr/next keep the last good descriptor.
- Reset asserted mid-beat drops cyc/stb asynchronously.

Optional Feature:
- Macro: SG_TIMEOUT_EN.
- When defined:
  - A per-beat counter starts when stb rises and clears on ack/err/rty.
  - Reaching TIMEOUT drops cyc/stb and enters ERROR with sg_state[7:4] frozen.
- When undefined: no counter exists and the engine waits indefinitely for a response.

Test Plan:
- start_i with start_adr_i=29'h0000_0200 (byte 0x1000), memory holding word0=0x0000_1234, word1=0x0004_0008, word2=0x0000_2001, zero-wait acks:
  - Beats at 0x1000, 0x1004, 0x1008.
  - desc_valid_o high 6 cycles after start.
  - sg_desc=16'h1234, sg_addr=29'h0000_8001, sg_next=29'h0000_0400, sg_state=8'h1C.
  - desc_done_i -> sg_state=8'h15 (DONE).
- Three-descriptor chain with EOC on the third:
  - Fetch addresses follow the next pointers.
  - sg_state[7:4] reads 1, 2, 3.
  - Ends in DONE.
- wbm_rty_i on the RD1 beat twice, then ack: same address re-issued twice and the fetch completes. Five consecutive rty (MAX_RTY=4) -> sg_state[2:0]=6.
- wbm_err_i on the RD2 beat: ERROR state; sg_desc retains the prior descriptor's value; a subsequent start_i restarts from RD0.
- abort_i in the same cycle as the RD1 ack: cyc/stb low the next cycle, FSM IDLE, sg_desc unchanged. Separately, 17 descriptors fetched -> count wraps to 1.
- SG_TIMEOUT_EN defined with TIMEOUT=8 and no ack: stb drops after 8 cycles and sg_state[2:0]=6. Undefined: stb stays high for 1000 cycles.
